// File: rtl/obi_stream_sbr.sv
// -----------------------------------------------------------------------------
// obi_stream_sbr
// OBI subordinate that bridges memory-mapped accesses to two 32-bit word
// streams. Writes to DATA push the TX FIFO (outbound stream); reads from DATA
// pop the RX FIFO (inbound stream). A full TX FIFO or an empty RX FIFO
// withholds the grant, so the manager stalls and no data is dropped.
//
// Register map (word index addr[11:2]):
//   0 ID     RO  MAGIC
//   1 DATA   W: push TX, R: pop RX
//   2 STATUS RO  [0] tx_full [1] tx_empty [2] rx_full [3] rx_empty
//                [4] timeout_sticky [15:8] tx_count [23:16] rx_count
//   3 CTRL   WO  [0] flush TX [1] flush RX [2] clear timeout_sticky
//   other        rdata 32'hDEADBEEF, err=1, writes ignored
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   sbr_req_i / sbr_rsp_o  OBI request / response
//   tx_valid_o, tx_ready_i, tx_data_o, tx_be_o   outbound stream
//   rx_valid_i, rx_ready_o, rx_data_i            inbound stream
//
// Optional build macro OBI_STREAM_TIMEOUT_EN: a DATA request stalled for
// TIMEOUT cycles is force-granted with an error response and sets
// timeout_sticky. Without it, stalls are unbounded and STATUS[4] reads 0.
// -----------------------------------------------------------------------------
package obi_stream_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    logic            req;
    sbr_obi_a_chan_t a;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    sbr_obi_r_chan_t r;
  } sbr_obi_rsp_t;

endpackage

module obi_stream_sbr
  import obi_stream_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 256,
  parameter logic [31:0] MAGIC   = 32'h5354524D
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  sbr_obi_req_t sbr_req_i,
  output sbr_obi_rsp_t sbr_rsp_o,
  output logic         tx_valid_o,
  input  logic         tx_ready_i,
  output logic [31:0]  tx_data_o,
  output logic [3:0]   tx_be_o,
  input  logic         rx_valid_i,
  output logic         rx_ready_o,
  input  logic [31:0]  rx_data_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

  // ---------------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------------
  logic [31:0]   tx_data_mem_r [DEPTH];
  logic [3:0]    tx_be_mem_r   [DEPTH];
  logic [AW-1:0] tx_wp_r, tx_rp_r;
  logic [CW-1:0] tx_cnt_r;

  logic [31:0]   rx_mem_r [DEPTH];
  logic [AW-1:0] rx_wp_r, rx_rp_r;
  logic [CW-1:0] rx_cnt_r;

  logic          rvalid_r;
  logic [31:0]   rdata_r;
  logic [3:0]    rid_r;
  logic          err_r;

  // ---------------------------------------------------------------------------
  // Decode and handshake
  // ---------------------------------------------------------------------------
  logic [9:0]  idx_s;
  logic        is_data_s;
  logic        tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic        stall_s, force_s, gnt_s, acc_s;
  logic        tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
  logic        ctrl_wr_s, tx_flush_s, rx_flush_s;
  logic        sticky_s;
  logic [31:0] status_s;
  logic [31:0] rdata_d_s;
  logic        err_d_s;
  logic        unused_s;

  assign idx_s      = sbr_req_i.a.addr[11:2];
  assign is_data_s  = (idx_s == 10'd1);

  assign tx_full_s  = (tx_cnt_r == CW'(DEPTH));
  assign tx_empty_s = (tx_cnt_r == CW'(0));
  assign rx_full_s  = (rx_cnt_r == CW'(DEPTH));
  assign rx_empty_s = (rx_cnt_r == CW'(0));

  // A DATA access that the FIFO cannot serve right now is held off.
  assign stall_s = sbr_req_i.req & is_data_s &
                   (sbr_req_i.a.we ? tx_full_s : rx_empty_s);
  assign gnt_s   = ~stall_s | force_s;
  assign acc_s   = sbr_req_i.req & gnt_s;

  // A forced (timed-out) grant must leave both FIFOs untouched.
  assign tx_push_s  = acc_s & is_data_s &  sbr_req_i.a.we & ~force_s;
  assign rx_pop_s   = acc_s & is_data_s & ~sbr_req_i.a.we & ~force_s;
  assign ctrl_wr_s  = acc_s & sbr_req_i.a.we & (idx_s == 10'd3);
  assign tx_flush_s = ctrl_wr_s & sbr_req_i.a.wdata[0];
  assign rx_flush_s = ctrl_wr_s & sbr_req_i.a.wdata[1];

  assign tx_valid_o = ~tx_empty_s;
  assign tx_pop_s   = tx_valid_o & tx_ready_i;
  assign rx_ready_o = ~rx_full_s;
  assign rx_push_s  = rx_valid_i & rx_ready_o;

  assign tx_data_o  = tx_data_mem_r[tx_rp_r];
  assign tx_be_o    = tx_be_mem_r[tx_rp_r];

  assign status_s = {8'h00, 8'(rx_cnt_r), 8'(tx_cnt_r), 3'b000, sticky_s,
                     rx_empty_s, rx_full_s, tx_empty_s, tx_full_s};

  // Address bits outside the word index are deliberately ignored.
  assign unused_s = ^{sbr_req_i.a.addr[31:12], sbr_req_i.a.addr[1:0], 32'(TIMEOUT)};

`ifdef OBI_STREAM_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  logic [TW-1:0] to_cnt_r;
  logic          to_sticky_r;
  logic          clr_to_s;

  // Grant is forced on the TIMEOUT-th cycle the stalled request is presented.
  assign force_s  = stall_s & (to_cnt_r == TW'(TIMEOUT - 1));
  assign clr_to_s = ctrl_wr_s & sbr_req_i.a.wdata[2];
  assign sticky_s = to_sticky_r;

  // Stall-cycle counter: restarts on any grant or when the request goes away.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt_r <= '0;
    end else if (!sbr_req_i.req || gnt_s) begin
      to_cnt_r <= '0;
    end else begin
      to_cnt_r <= to_cnt_r + TW'(1);
    end
  end

  // Sticky timeout flag, cleared only through CTRL.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_sticky_r <= 1'b0;
    end else if (force_s) begin
      to_sticky_r <= 1'b1;
    end else if (clr_to_s) begin
      to_sticky_r <= 1'b0;
    end else begin
      to_sticky_r <= to_sticky_r;
    end
  end
`else
  assign force_s  = 1'b0;
  assign sticky_s = 1'b0;
`endif

  // Response data selection for the request granted this cycle.
  always_comb begin
    rdata_d_s = 32'h0000_0000;
    err_d_s   = 1'b0;
    if (force_s) begin
      rdata_d_s = ERR_WORD;
      err_d_s   = 1'b1;
    end else begin
      case (idx_s)
        10'd0:   rdata_d_s = sbr_req_i.a.we ? 32'h0000_0000 : MAGIC;
        10'd1:   rdata_d_s = sbr_req_i.a.we ? 32'h0000_0000 : rx_mem_r[rx_rp_r];
        10'd2:   rdata_d_s = sbr_req_i.a.we ? 32'h0000_0000 : status_s;
        10'd3:   rdata_d_s = 32'h0000_0000;
        default: begin
          rdata_d_s = ERR_WORD;
          err_d_s   = 1'b1;
        end
      endcase
    end
  end

  // Response channel: one response per grant, issued on the following cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_r <= 1'b0;
      rdata_r  <= 32'h0000_0000;
      rid_r    <= 4'h0;
      err_r    <= 1'b0;
    end else if (acc_s) begin
      rvalid_r <= 1'b1;
      rdata_r  <= rdata_d_s;
      rid_r    <= sbr_req_i.a.aid;
      err_r    <= err_d_s;
    end else begin
      rvalid_r <= 1'b0;
    end
  end

  assign sbr_rsp_o.gnt     = gnt_s;
  assign sbr_rsp_o.rvalid  = rvalid_r;
  assign sbr_rsp_o.r.rdata = rdata_r;
  assign sbr_rsp_o.r.rid   = rid_r;
  assign sbr_rsp_o.r.err   = err_r;

  // TX FIFO: flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_wp_r  <= '0;
      tx_rp_r  <= '0;
      tx_cnt_r <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        tx_data_mem_r[i] <= 32'h0000_0000;
        tx_be_mem_r[i]   <= 4'h0;
      end
    end else if (tx_flush_s) begin
      tx_wp_r  <= '0;
      tx_rp_r  <= '0;
      tx_cnt_r <= '0;
    end else begin
      if (tx_push_s) begin
        tx_data_mem_r[tx_wp_r] <= sbr_req_i.a.wdata;
        tx_be_mem_r[tx_wp_r]   <= sbr_req_i.a.be;
        tx_wp_r                <= tx_wp_r + AW'(1);
      end
      if (tx_pop_s) begin
        tx_rp_r <= tx_rp_r + AW'(1);
      end
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_cnt_r <= tx_cnt_r + CW'(1);
        2'b01:   tx_cnt_r <= tx_cnt_r - CW'(1);
        default: tx_cnt_r <= tx_cnt_r;
      endcase
    end
  end

  // RX FIFO: flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_wp_r  <= '0;
      rx_rp_r  <= '0;
      rx_cnt_r <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        rx_mem_r[i] <= 32'h0000_0000;
      end
    end else if (rx_flush_s) begin
      rx_wp_r  <= '0;
      rx_rp_r  <= '0;
      rx_cnt_r <= '0;
    end else begin
      if (rx_push_s) begin
        rx_mem_r[rx_wp_r] <= rx_data_i;
        rx_wp_r           <= rx_wp_r + AW'(1);
      end
      if (rx_pop_s) begin
        rx_rp_r <= rx_rp_r + AW'(1);
      end
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_cnt_r <= rx_cnt_r + CW'(1);
        2'b01:   rx_cnt_r <= rx_cnt_r - CW'(1);
        default: rx_cnt_r <= rx_cnt_r;
      endcase
    end
  end

endmodule

// File: tb/tb_obi_stream_sbr.sv
// -----------------------------------------------------------------------------
// tb_obi_stream_sbr
// Directed self-checking bench for obi_stream_sbr. Inputs change 1 time unit
// after the rising edge; gnt is sampled at the falling edge, responses and
// stream outputs 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_obi_stream_sbr;
  import obi_stream_pkg::*;

`ifdef OBI_STREAM_TIMEOUT_EN
  localparam int unsigned TIMEOUT = 8;
`else
  localparam int unsigned TIMEOUT = 256;
`endif
  localparam logic [31:0] MAGIC = 32'h5354524D;

  logic         clk_i;
  logic         rst_ni;
  sbr_obi_req_t sbr_req;
  sbr_obi_rsp_t sbr_rsp;
  logic         tx_valid;
  logic         tx_ready;
  logic [31:0]  tx_data;
  logic [3:0]   tx_be;
  logic         rx_valid;
  logic         rx_ready;
  logic [31:0]  rx_data;

  int errors = 0;
  int checks = 0;

  obi_stream_sbr #(
    .DEPTH  (4),
    .TIMEOUT(TIMEOUT),
    .MAGIC  (MAGIC)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .sbr_req_i (sbr_req),
    .sbr_rsp_o (sbr_rsp),
    .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready),
    .tx_data_o (tx_data),
    .tx_be_o   (tx_be),
    .rx_valid_i(rx_valid),
    .rx_ready_o(rx_ready),
    .rx_data_i (rx_data)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // One OBI transfer, entered and left at posedge+1. Gives up after max_wait
  // stalled cycles and reports granted=0.
  task automatic obi_xfer(input logic [31:0] addr, input logic we,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [3:0] aid, input int max_wait,
                          output bit granted, output int waits,
                          output logic rvalid, output logic [31:0] rdata,
                          output logic err, output logic [3:0] rid);
    granted = 1'b0;
    waits   = 0;
    sbr_req.req     = 1'b1;
    sbr_req.a.addr  = addr;
    sbr_req.a.we    = we;
    sbr_req.a.wdata = wdata;
    sbr_req.a.be    = be;
    sbr_req.a.aid   = aid;
    while (!granted && waits <= max_wait) begin
      #4;
      if (sbr_rsp.gnt) granted = 1'b1;
      else waits++;
      @(posedge clk_i);
      #1;
    end
    sbr_req.req = 1'b0;
    rvalid = sbr_rsp.rvalid;
    rdata  = sbr_rsp.r.rdata;
    err    = sbr_rsp.r.err;
    rid    = sbr_rsp.r.rid;
  endtask

  task automatic test_reset();
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    #2;
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    checks++;
    if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready got=%b exp=1", rx_ready); end
    checks++;
    if ({sbr_rsp.rvalid, sbr_rsp.r.err, sbr_rsp.r.rid, sbr_rsp.r.rdata} !== 38'h0) begin
      errors++;
      $display("FAIL reset_rsp got rvalid=%b err=%b rid=%h rdata=%h exp all 0",
               sbr_rsp.rvalid, sbr_rsp.r.err, sbr_rsp.r.rid, sbr_rsp.r.rdata);
    end
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic test_id_status();
    bit g; int w; logic v; logic [31:0] d; logic e; logic [3:0] r;
    obi_xfer(32'h0000_0000, 1'b0, 32'h0, 4'hF, 4'h1, 4, g, w, v, d, e, r);
    checks++;
    if (!(g && w == 0 && v === 1'b1 && e === 1'b0 && r === 4'h1 && d === MAGIC)) begin
      errors++;
      $display("FAIL id_read got g=%0d w=%0d rvalid=%b err=%b rid=%h rdata=%h exp 1 0 1 0 1 %h",
               g, w, v, e, r, d, MAGIC);
    end
    obi_xfer(32'h0000_0008, 1'b0, 32'h0, 4'hF, 4'h2, 4, g, w, v, d, e, r);
    checks++;
    if (!(g && v === 1'b1 && e === 1'b0 && d === 32'h0000_000A)) begin
      errors++;
      $display("FAIL status_after_reset got rvalid=%b err=%b rdata=%h exp 1 0 0000000a", v, e, d);
    end
  endtask

  task automatic test_back_to_back();
    sbr_req.req     = 1'b1;
    sbr_req.a.addr  = 32'h0000_0000;
    sbr_req.a.we    = 1'b0;
    sbr_req.a.be    = 4'hF;
    sbr_req.a.wdata = 32'h0;
    sbr_req.a.aid   = 4'h4;
    #4;
    checks++;
    if (sbr_rsp.gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt0 got=%b exp=1", sbr_rsp.gnt); end
    @(posedge clk_i);
    #1;
    sbr_req.a.addr = 32'h0000_0008;
    sbr_req.a.aid  = 4'h5;
    checks++;
    if (!(sbr_rsp.rvalid === 1'b1 && sbr_rsp.r.rid === 4'h4 && sbr_rsp.r.rdata === MAGIC)) begin
      errors++;
      $display("FAIL b2b_rsp0 got rvalid=%b rid=%h rdata=%h exp 1 4 %h",
               sbr_rsp.rvalid, sbr_rsp.r.rid, sbr_rsp.r.rdata, MAGIC);
    end
    @(posedge clk_i);
    #1;
    sbr_req.req = 1'b0;
    checks++;
    if (!(sbr_rsp.rvalid === 1'b1 && sbr_rsp.r.rid === 4'h5 && sbr_rsp.r.rdata === 32'h0000_000A)) begin
      errors++;
      $display("FAIL b2b_rsp1 got rvalid=%b rid=%h rdata=%h exp 1 5 0000000a",
               sbr_rsp.rvalid, sbr_rsp.r.rid, sbr_rsp.r.rdata);
    end
    @(posedge clk_i);
    #1;
    checks++;
    if (sbr_rsp.rvalid !== 1'b0) begin errors++; $display("FAIL b2b_idle got rvalid=%b exp=0", sbr_rsp.rvalid); end
  endtask

  task automatic test_tx_backpressure();
    bit g; int w; logic v; logic [31:0] d; logic e; logic [3:0] r;
    logic [31:0] words [5];
    logic [3:0]  bes   [5];
    words = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    bes   = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h8};
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      obi_xfer(32'h0000_0004, 1'b1, words[i], bes[i], 4'h0, 4, g, w, v, d, e, r);
      checks++;
      if (!(g && w == 0 && v === 1'b1 && e === 1'b0 && d === 32'h0)) begin
        errors++;
        $display("FAIL tx_write%0d got g=%0d w=%0d rvalid=%b err=%b rdata=%h exp 1 0 1 0 0",
                 i, g, w, v, e, d);
      end
    end
    checks++;
    if (!(tx_valid === 1'b1 && tx_data === 32'h11 && tx_be === 4'hF)) begin
      errors++;
      $display("FAIL tx_head got valid=%b data=%h be=%h exp 1 00000011 f", tx_valid, tx_data, tx_be);
    end
    obi_xfer(32'h0000_0008, 1'b0, 32'h0, 4'hF, 4'h0, 4, g, w, v, d, e, r);
    checks++;
    if (d !== 32'h0000_0409) begin errors++; $display("FAIL tx_full_status got=%h exp=00000409", d); end
    fork
      obi_xfer(32'h0000_0004, 1'b1, words[4], bes[4], 4'h0, 10, g, w, v, d, e, r);
      begin
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        tx_ready = 1'b1;
        checks++;
        if (!(tx_valid === 1'b1 && tx_data === 32'h11)) begin
          errors++;
          $display("FAIL tx_emit_first got valid=%b data=%h exp 1 00000011", tx_valid, tx_data);
        end
        @(posedge clk_i); #1;
        tx_ready = 1'b0;
      end
    join
    checks++;
    if (!(g && w == 3)) begin errors++; $display("FAIL tx_stall_wait got granted=%0d waits=%0d exp 1 3", g, w); end
    obi_xfer(32'h0000_0008, 1'b0, 32'h0, 4'hF, 4'h0, 4, g, w, v, d, e, r);
    checks++;
    if (d !== 32'h0000_0409) begin errors++; $display("FAIL tx_count_stays got=%h exp=00000409", d); end
    for (int i = 1; i < 5; i++) begin
      tx_ready = 1'b1;
      checks++;
      if (!(tx_valid === 1'b1 && tx_data === words[i] && tx_be === bes[i])) begin
        errors++;
        $display("FAIL tx_drain%0d got valid=%b data=%h be=%h exp 1 %h %h",
                 i, tx_valid, tx_data, tx_be, words[i], bes[i]);
      end
      @(posedge clk_i); #1;
    end
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drained got valid=%b exp=0", tx_valid); end
  endtask

  task automatic test_rx_stream();
    bit g; int w; logic v; logic [31:0] d; logic e; logic [3:0] r;
    rx_valid = 1'b1; rx_data = 32'hA5A5A5A5;
    @(posedge clk_i); #1;
    rx_data = 32'h5A5A5A5A;
    @(posedge clk_i); #1;
    rx_valid = 1'b0;
    obi_xfer(32'h0000_0004, 1'b0, 32'h0, 4'hF, 4'h3, 4, g, w, v, d, e, r);
    checks++;
    if (!(g && w == 0 && v === 1'b1 && e === 1'b0 && r === 4'h3 && d === 32'hA5A5A5A5)) begin
      errors++;
      $display("FAIL rx_read0 got g=%0d w=%0d rvalid=%b err=%b rid=%h rdata=%h exp 1 0 1 0 3 a5a5a5a5",
               g, w, v, e, r, d);
    end
    obi_xfer(32'h0000_0004, 1'b0, 32'h0, 4'hF, 4'h7, 4, g, w, v, d, e, r);
    checks++;
    if (!(g && v === 1'b1 && r === 4'h7 && d === 32'h5A5A5A5A)) begin
      errors++;
      $display("FAIL rx_read1 got g=%0d rvalid=%b rid=%h rdata=%h exp 1 1 7 5a5a5a5a", g, v, r, d);
    end
    fork
      obi_xfer(32'h0000_0004, 1'b0, 32'h0, 4'hF, 4'h2, 6, g, w, v, d, e, r);
      begin
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rx_valid = 1'b1; rx_data = 32'hCAFEF00D;
        @(posedge clk_i); #1;
        rx_valid = 1'b0;
      end
    join
    checks++;
    if (!(g && w == 3 && r === 4'h2 && e === 1'b0 && d === 32'hCAFEF00D)) begin
      errors++;
      $display("FAIL rx_stalled_read got g=%0d w=%0d rid=%h err=%b rdata=%h exp 1 3 2 0 cafef00d",
               g, w, r, e, d);
    end
    obi_xfer(32'h0000_0008, 1'b0, 32'h0, 4'hF, 4'h0, 4, g, w, v, d, e, r);
    checks++;
    if (d !== 32'h0000_000A) begin errors++; $display("FAIL rx_empty_status got=%h exp=0000000a", d); end
  endtask

  task automatic test_flush();
    bit g; int w; logic v; logic [31:0] d; logic e; logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1; rx_data = 32'(i + 1);
      @(posedge clk_i); #1;
    end
    rx_data = 32'h99;
    checks++;
    if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_full_ready got=%b exp=0", rx_ready); end
    obi_xfer(32'h0000_0008, 1'b0, 32'h0, 4'hF, 4'h0, 4, g, w, v, d, e, r);
    checks++;
    if (d !== 32'h0004_0006) begin errors++; $display("FAIL rx_full_status got=%h exp=00040006", d); end
    obi_xfer(32'h0000_000C, 1'b1, 32'h2, 4'hF, 4'h1, 4, g, w, v, d, e, r);
    checks++;
    if (!(g && rx_ready === 1'b1)) begin errors++; $display("FAIL rx_flush_ready got g=%0d ready=%b exp 1 1", g, rx_ready); end
    rx_valid = 1'b0;
    obi_xfer(32'h0000_0008, 1'b0, 32'h0, 4'hF, 4'h0, 4, g, w, v, d, e, r);
    checks++;
    if (d !== 32'h0000_000A) begin errors++; $display("FAIL rx_flush_status got=%h exp=0000000a", d); end
    // TX flush with a stream handshake in the flush cycle: both entries vanish.
    tx_ready = 1'b0;
    obi_xfer(32'h0000_0004, 1'b1, 32'h77, 4'hF, 4'h0, 4, g, w, v, d, e, r);
    obi_xfer(32'h0000_0004, 1'b1, 32'h88, 4'hF, 4'h0, 4, g, w, v, d, e, r);
    tx_ready = 1'b1;
    obi_xfer(32'h0000_000C, 1'b1, 32'h1, 4'hF, 4'h0, 4, g, w, v, d, e, r);
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_flush_valid got=%b exp=0", tx_valid); end
  endtask

  task automatic test_unmapped();
    bit g; int w; logic v; logic [31:0] d; logic e; logic [3:0] r;
    obi_xfer(32'h0000_0024, 1'b0, 32'h0, 4'hF, 4'h5, 4, g, w, v, d, e, r);
    checks++;
    if (!(g && v === 1'b1 && e === 1'b1 && r === 4'h5 && d === 32'hDEADBEEF)) begin
      errors++;
      $display("FAIL unmapped_read got g=%0d rvalid=%b err=%b rid=%h rdata=%h exp 1 1 1 5 deadbeef",
               g, v, e, r, d);
    end
    obi_xfer(32'h0000_0024, 1'b1, 32'h1234, 4'hF, 4'h6, 4, g, w, v, d, e, r);
    checks++;
    if (!(g && e === 1'b1 && r === 4'h6)) begin
      errors++;
      $display("FAIL unmapped_write got g=%0d err=%b rid=%h exp 1 1 6", g, e, r);
    end
  endtask

  task automatic test_reset_mid_stall();
    bit g; int w; logic v; logic [31:0] d; logic e; logic [3:0] r;
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      obi_xfer(32'h0000_0004, 1'b1, 32'(i + 32'hA0), 4'hF, 4'h0, 4, g, w, v, d, e, r);
    end
    sbr_req.req     = 1'b1;
    sbr_req.a.addr  = 32'h0000_0004;
    sbr_req.a.we    = 1'b1;
    sbr_req.a.wdata = 32'h66;
    #4;
    checks++;
    if (sbr_rsp.gnt !== 1'b0) begin errors++; $display("FAIL full_stall_gnt got=%b exp=0", sbr_rsp.gnt); end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (!(tx_valid === 1'b0 && rx_ready === 1'b1 && sbr_rsp.rvalid === 1'b0)) begin
      errors++;
      $display("FAIL async_reset got tx_valid=%b rx_ready=%b rvalid=%b exp 0 1 0",
               tx_valid, rx_ready, sbr_rsp.rvalid);
    end
    sbr_req.req = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    obi_xfer(32'h0000_0008, 1'b0, 32'h0, 4'hF, 4'h0, 4, g, w, v, d, e, r);
    checks++;
    if (d !== 32'h0000_000A) begin errors++; $display("FAIL post_reset_status got=%h exp=0000000a", d); end
  endtask

`ifdef OBI_STREAM_TIMEOUT_EN
  task automatic test_timeout();
    bit g; int w; logic v; logic [31:0] d; logic e; logic [3:0] r;
    obi_xfer(32'h0000_0004, 1'b0, 32'h0, 4'hF, 4'h9, 20, g, w, v, d, e, r);
    checks++;
    if (!(g && w == 7 && e === 1'b1 && r === 4'h9 && d === 32'hDEADBEEF)) begin
      errors++;
      $display("FAIL timeout_grant got g=%0d w=%0d err=%b rid=%h rdata=%h exp 1 7 1 9 deadbeef",
               g, w, e, r, d);
    end
    obi_xfer(32'h0000_0008, 1'b0, 32'h0, 4'hF, 4'h0, 4, g, w, v, d, e, r);
    checks++;
    if (d !== 32'h0000_001A) begin errors++; $display("FAIL timeout_sticky got=%h exp=0000001a", d); end
    obi_xfer(32'h0000_000C, 1'b1, 32'h4, 4'hF, 4'h0, 4, g, w, v, d, e, r);
    obi_xfer(32'h0000_0008, 1'b0, 32'h0, 4'hF, 4'h0, 4, g, w, v, d, e, r);
    checks++;
    if (d !== 32'h0000_000A) begin errors++; $display("FAIL timeout_clear got=%h exp=0000000a", d); end
  endtask
`endif

  initial begin
    sbr_req  = '0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 32'h0;
    test_reset();
    test_id_status();
    test_back_to_back();
    test_tx_backpressure();
    test_rx_stream();
    test_flush();
    test_unmapped();
    test_reset_mid_stall();
`ifdef OBI_STREAM_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/obi_stream_sbr.md
Name: obi_stream_sbr

Overview:
- OBI subordinate (responder) that bridges the user-domain OBI bus to two 32-bit valid/ready word streams.
- Writes to the DATA register push into a TX FIFO, which drives an outbound stream.
- Reads from the DATA register pop an RX FIFO, which is filled by an inbound stream.
- Serves as the memory-mapped endpoint that the ascon read/write DMA managers target for streaming: grant back-pressure stalls the DMA instead of dropping data.

Parameters:
- DEPTH, 4: entries per FIFO; power of two, >=2.
- TIMEOUT, 256: maximum stalled-grant cycles (used only with the optional feature).
- MAGIC, 32'h5354524D: value returned by the ID register.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- sbr_req_i  in  sbr_obi_req_t  OBI request (req, a.addr, a.we, a.be, a.wdata, a.aid).
- sbr_rsp_o  out  sbr_obi_rsp_t  OBI response (gnt, rvalid, r.rdata, r.rid, r.err).
- tx_valid_o  out  1  outbound word valid.
- tx_ready_i  in  1  outbound word accepted.
- tx_data_o  out  32  outbound data.
- tx_be_o  out  4  outbound byte enables (a.be of the write).
- rx_valid_i  in  1  inbound word valid.
- rx_ready_o  out  1  inbound ready (= RX FIFO not full).
- rx_data_i  in  32  inbound data.

Interface decision: one clock, clk_i; reset rst_ni is asynchronous, active-low.

Behaviour:
- Register map, word index addr[11:2]:
  - 0 ID (RO, MAGIC).
  - 1 DATA (W pushes TX; R pops RX).
  - 2 STATUS (RO): [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] timeout_sticky, [15:8] tx_count, [23:16] rx_count.
  - 3 CTRL (WO, self-clearing): [0] flush TX, [1] flush RX, [2] clear timeout_sticky.
  - Any other index: rdata 32'hDEADBEEF, err=1; writes ignored.
- gnt is combinational: gnt=1 except when req and index==1 and either (we and TX full) or (!we and RX empty). A stalled request must be held by the manager.
- Every granted request produces exactly one response: rvalid=1 on the following cycle; rid = aid captured at grant; rdata/err registered at grant. Writes return rdata 0, err 0 (mapped addresses).
- Response bookkeeping: one outstanding response; back-to-back grants give back-to-back rvalid.
- DATA read data: the RX head word is captured and popped in the grant cycle.
- FIFOs: count width $clog2(DEPTH)+1, pointers wrap modulo DEPTH.
  - Push and pop in the same cycle: count unchanged; allowed when full (TX) only if a pop occurs. Gnt remains blocked on full, so OBI push into a full TX never happens.
  - tx_valid_o = !tx_empty; pop on tx_valid_o & tx_ready_i.
  - rx_ready_o = !rx_full; push on rx_valid_i & rx_ready_o.
  - tx_data_o/tx_be_o = head entry, combinational from storage.
- Flush has priority: the FIFO is emptied in the cycle after the CTRL grant. A concurrent stream handshake on that FIFO in the flush cycle is discarded.
- STATUS read in the same cycle as a push/pop returns pre-update values.
- Reset (async, any time): FIFOs empty, rvalid 0, rdata 0, rid 0, err 0, timeout_sticky 0, tx_valid_o 0, rx_ready_o 1. An in-flight response is lost.

Optional Feature:
- Macro: OBI_STREAM_TIMEOUT_EN.
- With the macro defined:
  - A counter increments each cycle a DATA request is held with gnt=0 and clears on any grant or on a dropped req.
  - When the counter reaches TIMEOUT, gnt is forced to 1 for that request. Its response has err=1, rdata 32'hDEADBEEF, no FIFO change, and timeout_sticky is set.
- Without the macro: no counter, stalls are unbounded, and STATUS[4] reads 0.

Test Plan:
- After reset, read idx0 -> rvalid next cycle, rdata 0x5354524D. Read idx2 -> rdata 0x0000000A (tx_empty, rx_empty).
- Write 0x11,0x22,0x33,0x44 to idx1 with tx_ready_i=0, then a 5th write -> gnt held 0. Raise tx_ready_i for one cycle -> 0x11 emitted, 5th write granted, tx_count stays 4.
- Drive rx 0xA5A5A5A5, 0x5A5A5A5A; read idx1 twice -> rdata in order, rid matches aid 3 and 7. A 3rd read stalls until rx_valid_i brings 0xCAFEF00D.
- Fill RX to 4 -> rx_ready_o=0. Write CTRL=0x2 while rx_valid_i=1 -> rx_count 0 next cycle, the concurrent word is dropped, and rx_ready_o=1.
- Read idx 9 -> err=1, rdata 0xDEADBEEF. Assert rst_ni=0 mid-stall with TX full -> tx_valid_o=0 immediately (async) and counts 0.
- With OBI_STREAM_TIMEOUT_EN and TIMEOUT=8: read idx1 with RX empty -> gnt on stall cycle 8, err=1, STATUS[4]=1. CTRL=0x4 clears it.
